// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, raster phase enum and renderer colour codes.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned PIX_DIV  = 4;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // RGB332 colour codes shared with the board renderer
    localparam logic [7:0] COLOR_BLACK  = 8'h00;
    localparam logic [7:0] COLOR_WHITE  = 8'hFF;
    localparam logic [7:0] COLOR_RED    = 8'hE0;
    localparam logic [7:0] COLOR_GREEN  = 8'h1C;
    localparam logic [7:0] COLOR_BLUE   = 8'h03;
    localparam logic [7:0] COLOR_YELLOW = 8'hFC;

    // Phase reached once the counter has moved to pos; boundaries are the first index of each phase.
    function automatic phase_t phase_step(phase_t ph, logic [9:0] pos,
                                          int unsigned act, int unsigned fp, int unsigned sync);
        phase_t nx;
        nx = ph;
        unique case (ph)
            PH_ACTIVE: if (pos == 10'(act))             nx = PH_FRONT;
            PH_FRONT:  if (pos == 10'(act + fp))        nx = PH_SYNC;
            PH_SYNC:   if (pos == 10'(act + fp + sync)) nx = PH_BACK;
            PH_BACK:   if (pos == '0)                   nx = PH_ACTIVE;
            default:                                    nx = PH_ACTIVE;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position/sync bundle from the timing generator to renderer and connector.
interface vga_timing_gen_if;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       line_end;
    logic       frame_end;

    modport master (
        output pix_en, hCount, vCount, bright, hSync, vSync, line_end, frame_end
    );

    modport slave (
        input pix_en, hCount, vCount, bright, hSync, vSync, line_end, frame_end
    );
endinterface

// File: rtl/vga_timing_gen_pix_en_div.sv
// pix_en_div: modulo-DIV clock-enable; tick is high on the clk whose edge completes each DIV-cycle period.
module pix_en_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, active-low syncs, bright and line/frame markers, all registered.
// Define VGA_TIMING_PIX_DIV_EN to derive the pixel advance from a faster clk through pix_en_div.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP
`ifdef VGA_TIMING_PIX_DIV_EN
    ,
    parameter int unsigned PIX_DIV  = vga_timing_pkg::PIX_DIV
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    import vga_timing_pkg::*;

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       adv;
    phase_t     h_ph, h_ph_nx, v_ph, v_ph_nx;
    logic [9:0] h_cnt, h_cnt_nx, v_cnt, v_cnt_nx;
    logic       h_wrap, v_wrap;
    logic       pix_en_q, bright_q, hsync_q, vsync_q, line_end_q, frame_end_q;

`ifdef VGA_TIMING_PIX_DIV_EN
    pix_en_div #(.DIV(PIX_DIV)) u_pix_en_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (adv)
    );
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        h_wrap   = (h_cnt == 10'(H_TOT - 1));
        v_wrap   = (v_cnt == 10'(V_TOT - 1));
        h_cnt_nx = h_cnt;
        v_cnt_nx = v_cnt;
        h_ph_nx  = h_ph;
        v_ph_nx  = v_ph;
        if (adv) begin
            h_cnt_nx = h_wrap ? '0 : h_cnt + 10'd1;
            h_ph_nx  = phase_step(h_ph, h_cnt_nx, H_ACTIVE, H_FP, H_SYNC);
            if (h_wrap) begin
                v_cnt_nx = v_wrap ? '0 : v_cnt + 10'd1;
                v_ph_nx  = phase_step(v_ph, v_cnt_nx, V_ACTIVE, V_FP, V_SYNC);
            end
        end
    end

    // Outputs are decoded from the next-state values so they line up with the counters they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_ph        <= PH_ACTIVE;
            v_ph        <= PH_ACTIVE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix_en_q    <= 1'b0;
            bright_q    <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            h_ph        <= h_ph_nx;
            v_ph        <= v_ph_nx;
            h_cnt       <= h_cnt_nx;
            v_cnt       <= v_cnt_nx;
            pix_en_q    <= adv;
            line_end_q  <= adv & h_wrap;
            frame_end_q <= adv & h_wrap & v_wrap;
            if (adv) begin
                bright_q <= (h_ph_nx == PH_ACTIVE) && (v_ph_nx == PH_ACTIVE);
                hsync_q  <= (h_ph_nx != PH_SYNC);
                vsync_q  <= (v_ph_nx != PH_SYNC);
            end
        end
    end

    assign vga.pix_en    = pix_en_q;
    assign vga.hCount    = h_cnt;
    assign vga.vCount    = v_cnt;
    assign vga.bright    = bright_q;
    assign vga.hSync     = hsync_q;
    assign vga.vSync     = vsync_q;
    assign vga.line_end  = line_end_q;
    assign vga.frame_end = frame_end_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size and shrunken-timing instances share a randomly pulsed reset and are
// checked every clk against a raster model computed from the advance count since reset release.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIX_DIV_EN
    localparam int unsigned TB_DIV = 4;
`else
    localparam int unsigned TB_DIV = 1;
`endif
    localparam int unsigned N_CYCLES = 26000;

    typedef struct {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       bright;
        logic       hs;
        logic       vs;
        logic       le;
        logic       fe;
    } exp_t;

    typedef struct {
        exp_t big;
        exp_t sm;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pair_t q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vif ();
    vga_timing_gen_if vif_s ();

    vga_timing_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif_s)
    );

    // k = clk edges seen since reset release; the raster position is the number of completed advances.
    function automatic exp_t model(int unsigned k,
                                   int unsigned ha, int unsigned hfp, int unsigned hs, int unsigned hbp,
                                   int unsigned va, int unsigned vfp, int unsigned vs, int unsigned vbp);
        exp_t e;
        int unsigned ht, vt, n, x, y;
        bit adv_now;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        n = k / TB_DIV;
        x = n % ht;
        y = (n / ht) % vt;
        adv_now  = (k > 0) && (k % TB_DIV == 0);
        e.pix_en = adv_now;
        e.h      = 10'(x);
        e.v      = 10'(y);
        e.bright = (n > 0) && (x < ha) && (y < va);
        e.hs     = !((x >= ha + hfp) && (x < ha + hfp + hs));
        e.vs     = !((y >= va + vfp) && (y < va + vfp + vs));
        e.le     = adv_now && (x == 0);
        e.fe     = adv_now && (x == 0) && (y == 0);
        return e;
    endfunction

    task automatic chk(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Stimulus: random reset pulses at random points; expected response queued per clk.
    initial begin
        int unsigned k = 0;
        int unsigned rst_left = 2;
        int unsigned seg_left = 7000 * TB_DIV;
        for (int c = 0; c < N_CYCLES; c++) begin
            @(posedge clk);
            if (rst_n) k++;
            else       k = 0;
            #2;
            if (!rst_n) begin
                if (rst_left == 0) rst_n = 1'b1;
                else               rst_left--;
            end else if (seg_left == 0) begin
                rst_n    = 1'b0;
                rst_left = $urandom_range(0, 3);
                seg_left = $urandom_range(300, 4000);
            end else begin
                seg_left--;
            end
            if (!rst_n) k = 0;
            q.push_back('{big: model(k, 640, 16, 96, 48, 480, 10, 2, 33),
                          sm:  model(k, 16, 2, 4, 3, 6, 2, 2, 3)});
        end
        @(negedge clk);
        #1;
        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: every clk is an output beat; compare away from the active edge.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                p = q.pop_front();
                chk("pix_en",      vif.pix_en,      p.big.pix_en);
                chk("hCount",      vif.hCount,      p.big.h);
                chk("vCount",      vif.vCount,      p.big.v);
                chk("bright",      vif.bright,      p.big.bright);
                chk("hSync",       vif.hSync,       p.big.hs);
                chk("vSync",       vif.vSync,       p.big.vs);
                chk("line_end",    vif.line_end,    p.big.le);
                chk("frame_end",   vif.frame_end,   p.big.fe);
                chk("s_pix_en",    vif_s.pix_en,    p.sm.pix_en);
                chk("s_hCount",    vif_s.hCount,    p.sm.h);
                chk("s_vCount",    vif_s.vCount,    p.sm.v);
                chk("s_bright",    vif_s.bright,    p.sm.bright);
                chk("s_hSync",     vif_s.hSync,     p.sm.hs);
                chk("s_vSync",     vif_s.vSync,     p.sm.vs);
                chk("s_line_end",  vif_s.line_end,  p.sm.le);
                chk("s_frame_end", vif_s.frame_end, p.sm.fe);
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640×480@60 Hz VGA raster timing: horizontal/vertical pixel counters, active-low sync pulses and the `bright` active-video qualifier. It is the source end of the `hCount`/`vCount`/`bright` interface consumed by the board renderer, and drives `hSync`/`vSync` straight to the VGA connector. It also emits one-cycle line and frame markers so game logic can update state during blanking.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `PIX_DIV`, 4: clk cycles per pixel; used only with `VGA_TIMING_PIX_DIV_EN`

Ports:
- `clk` in 1: system clock; rising edge only
- `rst_n` in 1: asynchronous, active-low reset
- `pix_en` out 1: pixel-advance strobe
- `hCount` out 10: X coordinate, 0..H_TOTAL-1
- `vCount` out 10: Y coordinate, 0..V_TOTAL-1
- `bright` out 1: high when hCount < H_ACTIVE and vCount < V_ACTIVE
- `hSync` out 1: active-low horizontal sync
- `vSync` out 1: active-low vertical sync
- `line_end` out 1: one-clk pulse on the pixel advance that wraps hCount to 0
- `frame_end` out 1: one-clk pulse on the pixel advance that wraps both counters to 0

## Operation
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal phase FSM: ACTIVE (0..639) → FRONT (640..655) → SYNC (656..751) → BACK (752..799) → ACTIVE. Transitions occur only on a pixel advance.
- Vertical phase FSM has the same four states over lines: ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524. It steps only on a pixel advance where hCount = H_TOTAL-1.
- On each pixel advance: hCount increments, or wraps to 0 at H_TOTAL-1. On that wrap, vCount increments, or wraps to 0 at V_TOTAL-1.
- hSync = 0 exactly when H FSM is in SYNC. vSync = 0 exactly when V FSM is in SYNC. bright = H ACTIVE and V ACTIVE.
- All outputs are registered and computed from next-state values, so on every clk hCount, vCount, bright, hSync and vSync describe the same pixel.
- Counters never exceed TOTAL-1.

## Timing
- Reset values: hCount=0, vCount=0, bright=0, hSync=1, vSync=1, line_end=0, frame_end=0, pix_en=0, both FSMs ACTIVE, divider count 0.
- bright stays 0 after reset until the first pixel advance, which yields (1,0) with bright=1. Pixel (0,0) first shows bright=1 after the first frame wrap.
- Latency is one clk from the pixel advance to the updated outputs.
- line_end and frame_end are high for exactly one clk, in the same cycle as the wrapped counter values. frame_end implies line_end.
- Reset asserted mid-frame returns all state to reset values immediately. Counting restarts at the first clk after release.
- Line period: 800 pixel advances. Frame period: 420000 pixel advances.

## Configuration
- `VGA_TIMING_PIX_DIV_EN` undefined:
  - clk is the ≈25 MHz pixel clock.
  - pix_en is tied to 1 after reset, so every clk is a pixel advance.
- `VGA_TIMING_PIX_DIV_EN` defined:
  - clk is the 100 MHz board clock.
  - A modulo-PIX_DIV counter raises pix_en for one clk in every PIX_DIV. The first pulse comes on the PIX_DIV-th clk after reset release.
  - Outputs are held between pulses, and consumers must qualify with pix_en.

## Structure
- `vga_timing_pkg` holds:
  - the 640×480 timing constants and derived H_TOTAL/V_TOTAL
  - the phase enum (ACTIVE, FRONT, SYNC, BACK)
  - the color-code constants shared with the renderer
- One sub-module, `pix_en_div`: parameterised clock-enable divider. It is instantiated only when `VGA_TIMING_PIX_DIV_EN` is defined.

## Test plan
- Reset, then release; macro off → first clk gives hCount=1, vCount=0, bright=1, hSync=1; pix_en=1 every clk.
- Run to hCount=655→656 → hSync falls on the 656 cycle. At 752 → hSync rises. Low for exactly 96 pixels.
- Run to hCount=799 → next cycle hCount=0, vCount+1, line_end=1 for one clk. bright=0 for hCount 640..799.
- Full frame → vSync low exactly for vCount 490..491 (1600 pixels). frame_end=1 once per 420000 pixels, at (0,0).
- Assert rst_n at (700, 300) for 3 clks → outputs equal reset values asynchronously. After release, count resumes from (1,0).
- Macro on, PIX_DIV=4 → pix_en high 1-in-4 clks. Counters change only on those clks. The line takes 3200 clks.
